// File: rtl/mac_dot_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl_if
// Bundles every non-clock signal of the dot-product controller.
//
// Handshake rule for both streams (operand in_*, result out_*): a transfer
// happens on a rising clk edge where valid && ready are both high. The
// producer keeps its data stable while valid is high and ready is low. ready
// may depend combinationally on the controller state and on abort, never on
// valid.
//
// Signal groups
//   job control : start, vec_len, abort (in), busy (out)
//   operand in  : in_valid, act_in, w_in (in), in_ready (out)
//   MAC side    : mac_en, mac_act, mac_w (out), mac_result (in, registered)
//   result out  : out_valid, out_sum (out), out_ready (in)
//
// Modports
//   slave  : the controller
//   master : the environment (job issuer, operand source, MAC, consumer)
// ---------------------------------------------------------------------------
interface mac_dot_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = DATA_WIDTH + 16,
   parameter int LEN_WIDTH  = 8
);
   logic                    start;
   logic [LEN_WIDTH-1:0]    vec_len;
   logic                    abort;
   logic                    busy;

   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   act_in;
   logic [DATA_WIDTH-1:0]   w_in;

   logic                    mac_en;
   logic [DATA_WIDTH-1:0]   mac_act;
   logic [DATA_WIDTH-1:0]   mac_w;
   logic [2*DATA_WIDTH-1:0] mac_result;

   logic                    out_valid;
   logic                    out_ready;
   logic [ACC_WIDTH-1:0]    out_sum;

   modport slave (
      input  start, vec_len, abort, in_valid, act_in, w_in, mac_result, out_ready,
      output busy, in_ready, mac_en, mac_act, mac_w, out_valid, out_sum
   );

   modport master (
      output start, vec_len, abort, in_valid, act_in, w_in, mac_result, out_ready,
      input  busy, in_ready, mac_en, mac_act, mac_w, out_valid, out_sum
   );
endinterface

// File: rtl/mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl
// Sequences an external MAC (registered multiplier, one cycle latency) over
// vec_len operand pairs and accumulates the products into a signed dot
// product that is presented on a valid/ready output.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high
//   bus          : mac_dot_ctrl_if.slave (job control, operand stream,
//                  MAC side, result stream)
//   o_dbg_state  : current FSM state (IDLE=0, RUN=1, DRAIN=2, OUT=3)
//
// Flow: IDLE --start--> RUN (or OUT when vec_len==0) --last pair--> DRAIN
//       --> OUT --out_ready--> IDLE.  abort from any non-IDLE state -> IDLE.
// ---------------------------------------------------------------------------
module mac_dot_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = DATA_WIDTH + 16,
   parameter int LEN_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   mac_dot_ctrl_if.slave     bus,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_next;

   logic [LEN_WIDTH-1:0]    r_len;
   logic [LEN_WIDTH-1:0]    r_cnt;
   logic [ACC_WIDTH-1:0]    r_acc;
   logic                    r_pend;

   logic                    w_in_ready;
   logic                    w_hs;
   logic                    w_last;
   logic                    w_abort;
   logic                    w_accept;
   logic [ACC_WIDTH-1:0]    w_prod_ext;

   // abort only matters once a job is running; in IDLE start is honoured.
   assign w_abort    = bus.abort && (r_state != S_IDLE);
   assign w_accept   = (r_state == S_IDLE) && bus.start;

   // Dropping in_ready under abort gives abort priority over a handshake.
   assign w_in_ready = (r_state == S_RUN) && !bus.abort;
   assign w_hs       = bus.in_valid && w_in_ready;

   // r_len is at least 1 whenever RUN is entered, so len-1 cannot underflow.
   assign w_last     = (r_cnt == (r_len - LEN_WIDTH'(1)));

   // Sign-extend the product to accumulator width.
   assign w_prod_ext = ACC_WIDTH'($signed(bus.mac_result));

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.in_ready  = w_in_ready;
   assign bus.mac_en    = w_hs;
   assign bus.mac_act   = bus.act_in;
   assign bus.mac_w     = bus.w_in;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = (r_state == S_OUT);
   assign bus.out_sum   = r_acc;
   assign o_dbg_state   = r_state;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = (bus.vec_len == '0) ? S_OUT : S_RUN;
            end
         end
         S_RUN: begin
            if (w_hs && w_last) begin
               w_next = S_DRAIN;
            end
         end
         // DRAIN always holds exactly one pending product (the last pair);
         // it is added on the edge that leaves DRAIN, so OUT sees the total.
         S_DRAIN: w_next = S_OUT;
         S_OUT: begin
            if (bus.out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (w_abort) begin
         w_next = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: length capture, pair count, pending flag, accumulator
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len  <= '0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_pend <= 1'b0;
      end else begin
         // mac_result is valid the cycle after mac_en, so the handshake is
         // remembered for one cycle and consumed then. w_hs is already low
         // under abort, which clears the flag.
         r_pend <= w_hs;
         if (w_accept) begin
            r_len <= bus.vec_len;
            r_cnt <= '0;
            r_acc <= '0;
         end else if (w_abort) begin
            r_cnt <= '0;
            r_acc <= '0;
         end else begin
            if (w_hs) begin
               r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
            if (r_pend) begin
               r_acc <= r_acc + w_prod_ext;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_ctrl
// Drives dot-product jobs into mac_dot_ctrl with a registered-multiplier MAC
// stub. Each job's expected sum is the plain integer sum of the operand
// products, wrapped to ACC_WIDTH, queued in exp_q and compared whenever
// out_valid is high. Directed jobs pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_mac_dot_ctrl;

   localparam int DW = 8;
   localparam int AW = DW + 16;
   localparam int LW = 8;
   localparam int PW = 2 * DW;

   logic          clk;
   logic          reset;
   logic [1:0]    dbg_state;

   mac_dot_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   mac_dot_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int                n_checks = 0;
   int                n_fail   = 0;
   logic [AW-1:0]     exp_q[$];
   logic signed [DW-1:0] act_a [0:255];
   logic signed [DW-1:0] w_a   [0:255];
   logic [AW-1:0]     dummy;

   function automatic void check(input string name, input logic signed [63:0] act,
                                 input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- MAC stub: registered product, garbage otherwise ----------------
   always @(posedge clk) begin
      if (bus.mac_en) begin
         bus.mac_result <= PW'(longint'($signed(bus.mac_act)) * longint'($signed(bus.mac_w)));
      end else begin
         bus.mac_result <= PW'($urandom);
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!reset) begin
         check("mac_act_pass", bus.mac_act, bus.act_in);
         check("mac_w_pass", bus.mac_w, bus.w_in);
         if (bus.mac_en) check("mac_en_needs_hs", bus.in_valid & bus.in_ready, 1);
         if (bus.in_ready | bus.out_valid) check("busy_when_active", bus.busy, 1);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", bus.out_valid, 0);
            end else begin
               check("out_sum", $signed(bus.out_sum), $signed(exp_q[0]));
               if (bus.out_ready) dummy = exp_q.pop_front();
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one job from IDLE. Entered and left at posedge+1.
   // mode: 0 = in_valid always high, 1 = toggled every other cycle, 2 = random.
   task automatic run_job(input int len, input int mode, input int hold,
                          input longint exp_lit, input bit use_lit);
      longint        sum;
      logic [AW-1:0] e;
      int            k;
      int            cyc;
      bit            v;
      bus.start    = 1'b1;
      bus.vec_len  = LW'(len);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_in_ready", bus.in_ready, 0);
      step();
      bus.start   = 1'b0;
      bus.vec_len = LW'($urandom);
      sum = 0;
      for (int i = 0; i < len; i++) sum += longint'(act_a[i]) * longint'(w_a[i]);
      e = sum[AW-1:0];
      if (use_lit) check("model_pin", $signed(e), exp_lit);
      if (len > 0) begin
         k = 0;
         cyc = 0;
         while (k < len && cyc < 4000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.act_in   = v ? act_a[k] : DW'($urandom);
            bus.w_in     = v ? w_a[k]   : DW'($urandom);
            bus.start    = 1'($urandom_range(0, 1));
            bus.vec_len  = LW'($urandom);
            @(negedge clk);
            check("run_in_ready", bus.in_ready, 1);
            check("run_mac_en", bus.mac_en, v);
            check("run_out_valid", bus.out_valid, 0);
            step();
            if (v) k++;
            cyc++;
         end
         if (k < len) check("run_timeout_pairs", k, len);
         // DRAIN: any offered pair must be refused
         bus.start    = 1'b0;
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.act_in   = DW'($urandom);
         bus.w_in     = DW'($urandom);
         exp_q.push_back(e);
         @(negedge clk);
         check("drain_in_ready", bus.in_ready, 0);
         check("drain_mac_en", bus.mac_en, 0);
         check("drain_out_valid", bus.out_valid, 0);
         check("drain_busy", bus.busy, 1);
         step();
         bus.in_valid = 1'b0;
      end else begin
         exp_q.push_back(e);
      end
      for (int h = 0; h < hold; h++) begin
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("out_hold_valid", bus.out_valid, 1);
         check("out_hold_mac_en", bus.mac_en, 0);
         if (use_lit) check("out_hold_sum_lit", $signed(bus.out_sum), exp_lit);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("out_valid", bus.out_valid, 1);
      if (use_lit) check("out_sum_lit", $signed(bus.out_sum), exp_lit);
      step();
      bus.out_ready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.vec_len   = '0;
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.act_in    = '0;
      bus.w_in      = '0;
      bus.out_ready = 1'b0;

      // reset values, during and right after reset
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_mac_en", bus.mac_en, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_dbg_state", dbg_state, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_out_valid", bus.out_valid, 0);
      check("post_rst_out_sum", bus.out_sum, 0);
      step();

      // four pairs, no stalls
      act_a[0] = 1;    w_a[0] = 2;
      act_a[1] = 3;    w_a[1] = 4;
      act_a[2] = -5;   w_a[2] = 6;
      act_a[3] = 127;  w_a[3] = -128;
      run_job(4, 0, 0, -16272, 1);

      // empty vector
      run_job(0, 0, 1, 0, 1);

      // three (-128,-128) pairs, toggled in_valid, consumer stalls 5 cycles
      for (int i = 0; i < 3; i++) begin act_a[i] = -128; w_a[i] = -128; end
      run_job(3, 1, 5, 49152, 1);
      @(negedge clk);
      check("idle_after_out_ready", bus.busy, 0);
      step();

      // longest vector, largest magnitude products
      for (int i = 0; i < 255; i++) begin act_a[i] = -128; w_a[i] = -128; end
      run_job(255, 0, 0, 4177920, 1);

      // abort in RUN after two pairs, abort wins over a simultaneous handshake
      bus.start   = 1'b1;
      bus.vec_len = 8'd6;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.act_in   = 8'd9;
         bus.w_in     = 8'd11;
         @(negedge clk);
         check("abort_pre_mac_en", bus.mac_en, 1);
         step();
      end
      bus.in_valid = 1'b1;
      bus.abort    = 1'b1;
      @(negedge clk);
      check("abort_mac_en", bus.mac_en, 0);
      step();
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_out_valid", bus.out_valid, 0);
      step();
      act_a[0] = 2; w_a[0] = 3;
      run_job(1, 0, 0, 6, 1);

      // abort while holding a result in OUT
      bus.start   = 1'b1;
      bus.vec_len = '0;
      step();
      bus.start = 1'b0;
      exp_q.push_back('0);
      bus.abort = 1'b1;
      @(negedge clk);
      check("abort_out_before", bus.out_valid, 1);
      step();
      bus.abort = 1'b0;
      dummy = exp_q.pop_front();
      @(negedge clk);
      check("abort_out_after_valid", bus.out_valid, 0);
      check("abort_out_after_busy", bus.busy, 0);
      step();

      // asynchronous reset in the middle of RUN
      bus.start   = 1'b1;
      bus.vec_len = 8'd10;
      step();
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.act_in   = 8'd5;
      bus.w_in     = 8'd7;
      step();
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_mac_en", bus.mac_en, 0);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_sum", bus.out_sum, 0);
      bus.in_valid = 1'b0;
      step();
      reset = 1'b0;
      act_a[0] = -7; w_a[0] = 9;
      act_a[1] = 4;  w_a[1] = 4;
      run_job(2, 2, 1, -47, 1);

      // randomized back-to-back jobs
      for (int j = 0; j < 25; j++) begin
         int len;
         len = $urandom_range(0, 16);
         for (int i = 0; i < len; i++) begin
            act_a[i] = DW'($urandom);
            w_a[i]   = DW'($urandom);
         end
         run_job(len, 2, $urandom_range(0, 3), 0, 0);
      end

      @(negedge clk);
      check("final_idle", bus.busy, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
